imem_loader: RTL

- Writer-side companion to the byte-addressed, big-endian instruction memory.
- Accepts a byte stream over a valid/ready handshake and packs every 4 bytes into one 32-bit word; the first byte received lands in the word's MSB.
- Each word is written through a single-cycle write strobe at consecutive word-aligned byte addresses from 0.
- Holds busy high while loading so the pipeline front end stays stalled until the program image is in place.

---
 rtl/imem_loader_if.sv | 33 +++
 rtl/imem_loader.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/imem_loader_if.sv
// imem_loader_if: command, byte-stream and memory-write bundle for imem_loader.
//   start/len_words          : load request and length in 32-bit words
//   byte_valid/byte_data     : incoming program byte stream
//   byte_ready               : loader accepts a byte this cycle
//   wr_en/wr_addr/wr_data    : single-cycle word write towards instruction memory
//   busy/done/err/checksum   : loader status
// Modport slave is the loader side; modport master is the host/memory side.
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              start;
  logic [ADDR_W-1:0] len_words;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              busy;
  logic              done;
  logic              err;
  logic [7:0]        checksum;

  modport slave (
    input  start, len_words, byte_valid, byte_data,
    output byte_ready, wr_en, wr_addr, wr_data, busy, done, err, checksum
  );

  modport master (
    output start, len_words, byte_valid, byte_data,
    input  byte_ready, wr_en, wr_addr, wr_data, busy, done, err, checksum
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: packs a valid/ready byte stream into big-endian 32-bit words
// (first byte in the MSB) and writes them to instruction memory at byte
// addresses 0, 4, 8, ... Holds busy while loading.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : imem_loader_if.slave (start/len_words, byte stream, write port,
//           busy/done/err/checksum)
// Optional: define IMEM_LOADER_CHECKSUM_EN to generate the running modulo-256
// byte checksum; otherwise checksum is tied to zero.
module imem_loader #(
  parameter int unsigned MEM_BYTES = 128,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  imem_loader_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_WRITE,
    ST_DONE
  } state_e;

  // Comparing len_words against the word capacity avoids the len*4 overflow.
  localparam logic [ADDR_W-1:0] MAX_WORDS = ADDR_W'(MEM_BYTES / 4);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] word_idx_q, word_idx_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       asm_q, asm_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic              err_q, err_d;

  logic oversize;
  logic accept;
  logic xfer;
  logic byte_ready_c, wr_en_c, busy_c, done_c;

  assign oversize = bus.len_words > MAX_WORDS;
  assign accept   = (state_q == ST_IDLE) && bus.start && !oversize;
  assign xfer     = (state_q == ST_COLLECT) && bus.byte_valid;

  always_comb begin
    state_d      = state_q;
    word_idx_d   = word_idx_q;
    len_d        = len_q;
    byte_cnt_d   = byte_cnt_q;
    asm_d        = asm_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    err_d        = 1'b0;
    byte_ready_c = 1'b0;
    wr_en_c      = 1'b0;
    busy_c       = 1'b0;
    done_c       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.len_words == '0) begin
            state_d = ST_DONE;
          end else if (oversize) begin
            err_d = 1'b1;
          end else begin
            state_d    = ST_COLLECT;
            word_idx_d = '0;
            byte_cnt_d = '0;
            len_d      = bus.len_words;
          end
        end
      end

      ST_COLLECT: begin
        byte_ready_c = 1'b1;
        busy_c       = 1'b1;
        if (bus.byte_valid) begin
          asm_d      = {asm_q[23:0], bus.byte_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            // Address/data registered here so they stay put after WRITE.
            state_d   = ST_WRITE;
            wr_addr_d = {word_idx_q[ADDR_W-3:0], 2'b00};
            wr_data_d = {asm_q[23:0], bus.byte_data};
          end
        end
      end

      ST_WRITE: begin
        wr_en_c = 1'b1;
        busy_c  = 1'b1;
        if (word_idx_q + ADDR_W'(1) == len_q) begin
          state_d = ST_DONE;
        end else begin
          word_idx_d = word_idx_q + ADDR_W'(1);
          byte_cnt_d = '0;
          state_d    = ST_COLLECT;
        end
      end

      ST_DONE: begin
        done_c  = 1'b1;
        busy_c  = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      word_idx_q <= '0;
      len_q      <= '0;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_idx_q <= word_idx_d;
      len_q      <= len_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      err_q      <= err_d;
    end
  end

  assign bus.byte_ready = byte_ready_c;
  assign bus.wr_en      = wr_en_c;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.busy       = busy_c;
  assign bus.done       = done_c;
  assign bus.err        = err_q;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] cks_q, cks_d;

  always_comb begin
    cks_d = cks_q;
    if (accept) begin
      cks_d = '0;
    end else if (xfer) begin
      cks_d = cks_q + bus.byte_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cks_q <= '0;
    end else begin
      cks_q <= cks_d;
    end
  end

  assign bus.checksum = cks_q;
`else
  logic unused_cks;
  assign unused_cks   = accept ^ xfer;
  assign bus.checksum = 8'h00;
`endif

endmodule
